// File: rtl/apb_slave_regfile_pkg.sv
// Shared types and constants for the APB register-file slave.
// Window decode is 12 bits, of which bits [11:2] form the register index.
package apb_slave_pkg;

  typedef enum logic {IDLE, ACCESS} apb_slv_state_e;

  localparam int APB_DW     = 32;
  localparam int APB_WIN_AW = 12;
  localparam int IDX_W      = APB_WIN_AW - 2;

  localparam logic [APB_DW-1:0] STATUS_WRAP = 32'hFFFF_FFFF;

  typedef struct packed {
    logic              write;
    logic [IDX_W-1:0]  idx;
    logic [APB_DW-1:0] wdata;
  } apb_req_t;

  // RW registers occupy 0..nregs-1 and STATUS sits at nregs.
  function automatic logic idx_valid(input logic [IDX_W-1:0] idx, input int nregs);
    return 32'(idx) <= 32'(nregs);
  endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the master decoder and the register-file slave.
interface apb_slave_regfile_if;
  import apb_slave_pkg::*;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [31:0]       PADDR;
  logic [APB_DW-1:0] PWDATA;
  logic [APB_DW-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_slave_regfile_wait_cnt.sv
// Wait-state down-counter: loaded on SETUP, counts down during ACCESS.
// done is decoded from the registered count only.
module apb_wait_cnt #(
  parameter int unsigned LOAD_VAL = 0
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic load,
  input  logic en,
  output logic done
);

  logic [3:0] cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                cnt <= '0;
    else if (load)               cnt <= 4'(LOAD_VAL);
    else if (en && cnt != 4'd0)  cnt <= cnt - 4'd1;
  end

  assign done = (cnt == 4'd0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with NUM_REGS RW registers plus a read-only write-count STATUS.
// PREADY/PSLVERR/PRDATA are gated by registered state and PSEL/PENABLE only.
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int NUM_REGS    = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                        PCLK,
  input  logic                        PRESETn,
  apb_slave_regfile_if.slave          apb,
  output logic [NUM_REGS*APB_DW-1:0]  regs_o,
  output logic [NUM_REGS-1:0]         wr_pls_o
);

  apb_slv_state_e state;

  apb_req_t                         req;
  logic                             setup, access_ph, cnt_done;
  logic                             ready, is_status, err, wr_commit;
  logic [NUM_REGS-1:0]              wr_hit;
  logic [NUM_REGS-1:0][APB_DW-1:0]  regs;
  logic [APB_DW-1:0]                status, rd_mux;
  logic                             unused_addr;

  assign req.write = apb.PWRITE;
  assign req.idx   = apb.PADDR[APB_WIN_AW-1:2];
  assign req.wdata = apb.PWDATA;
  assign unused_addr = ^{apb.PADDR[31:APB_WIN_AW], apb.PADDR[1:0]};

  assign setup     = apb.PSEL & ~apb.PENABLE;
  assign access_ph = (state == ACCESS) & apb.PSEL & apb.PENABLE;

  apb_wait_cnt #(.LOAD_VAL(WAIT_STATES)) u_wait_cnt (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .load    (setup),
    .en      (access_ph),
    .done    (cnt_done)
  );

  // A SETUP seen while still in ACCESS restarts the transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else begin
      case (state)
        IDLE:    if (setup) state <= ACCESS;
        ACCESS:  if (!apb.PSEL || (apb.PENABLE && cnt_done)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready     = access_ph & cnt_done;
  assign is_status = (32'(req.idx) == 32'(NUM_REGS));
  assign err       = ~idx_valid(req.idx, NUM_REGS) | (req.write & is_status);
  assign wr_commit = ready & req.write & ~err;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    assign wr_hit[k] = wr_commit & (req.idx == IDX_W'(k));
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      regs     <= '0;
      wr_pls_o <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++)
        if (wr_hit[k]) regs[k] <= req.wdata;
      wr_pls_o <= wr_hit;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)       status <= '0;
    else if (wr_commit) status <= (status == STATUS_WRAP) ? '0 : status + 32'd1;
  end

  always_comb begin
    rd_mux = '0;
    if (is_status) rd_mux = status;
    for (int k = 0; k < NUM_REGS; k++)
      if (req.idx == IDX_W'(k)) rd_mux = regs[k];
  end

  assign apb.PREADY  = ready;
  assign apb.PSLVERR = ready & err;
  assign apb.PRDATA  = (ready & ~req.write & ~err) ? rd_mux : '0;
  assign regs_o      = regs;

endmodule
